setting_register: RTL and testbench
===================================

Name: setting_register

Overview:
- Single addressable configuration register on the serial settings bus (7-bit address, 32-bit data, one-cycle write strobe).
- Loads the bus data when the strobe coincides with a match on its compile-time address, then holds it.
- Instantiated once per setting by DSP blocks such as the DDS phase accumulator, which uses its output as the frequency word.
- Provides a one-cycle "changed" pulse on every accepted write.

Parameters:
- MY_ADDR, 0, bus address this register responds to (0..2**ADDR_WIDTH-1).
- WIDTH, 32, width of the stored value and of the `out` port; the low WIDTH bits of `in` are stored.
- ADDR_WIDTH, 7, width of the `addr` bus.
- INIT, 0, value loaded into `out` on reset (WIDTH bits).

Ports:
- clock  in  1  rising-edge clock, the only clock domain.
- reset  in  1  asynchronous, active-low reset (low = in reset).
- strobe  in  1  one-cycle write strobe of the settings bus.
- addr  in  ADDR_WIDTH  target address of the current write.
- in  in  32  write data.
- out  out  WIDTH  registered setting value.
- changed  out  1  one-cycle pulse, high the cycle after an accepted write.

Behaviour:
- Reset asserted (low), asynchronously and independent of clock: out = INIT, changed = 0.
- Reset deassertion is synchronised by the user. The first write can be accepted on the first rising edge with reset high.
- Accepted write: strobe=1 and addr==MY_ADDR at a rising edge.
  - out <= in[WIDTH-1:0] and changed <= 1 at that edge.
  - Latency is 1 clock: the value is visible on `out` in the cycle after the strobe.
- Otherwise at each edge: out holds and changed <= 0.
- changed is a pulse, never sticky:
  - Back-to-back accepted writes keep it high for each of those cycles.
  - A write of a value identical to the current `out` still pulses changed.
- Address mismatch with strobe=1: no effect on out or changed.
- strobe=0: addr and in are don't-care; X on them must not propagate.
- Comparison is a full ADDR_WIDTH equality. No partial decode, no wrap-around.
- WIDTH < 32 truncates the upper bits of `in`. WIDTH > 32 is illegal; flag it with an elaboration-time check.
- Reset asserted mid-write wins: out = INIT, changed = 0 regardless of strobe.
- No read path and no bus acknowledge. Multiple instances on one bus must use distinct MY_ADDR values (not checked in hardware).

Optional Feature:
- Macro SETTING_REG_SHADOW_EN.
- Defined:
  - Adds input port `commit` (1 bit) and an internal shadow register, reset to INIT.
  - An accepted write loads the shadow only.
  - A rising edge with commit=1 copies shadow to out and pulses changed.
  - Write and commit in the same cycle: out receives the new `in` value directly (write-through), and the shadow is also updated.
  - A commit with no pending write still pulses changed.
- Undefined: no `commit` port and no shadow; behaviour exactly as above.

Decomposition:
- Shared package `settings_bus_pkg`:
  - localparam SETTINGS_ADDR_WIDTH = 7.
  - localparam SETTINGS_DATA_WIDTH = 32.
  - typedef settings_addr_t (logic [6:0]).
  - typedef settings_data_t (logic [31:0]).
  - Named address constants (e.g. FREQADDR and PHASEADDR slots) used by instantiating blocks.
- Optional sub-module `settings_addr_match` (strobe and address comparator producing the write-enable) is natural. It is reusable by blocks such as the phase accumulator that snoop a bus address directly.
- Everything else stays flat.

Test Plan:
- Reset: MY_ADDR=5, INIT=0; hold reset low -> out=0x00000000, changed=0. Assert reset low asynchronously mid-cycle after a write -> out returns to 0 immediately.
- Matching write: strobe=1, addr=5, in=0x12345678 for one cycle -> next cycle out=0x12345678 and changed=1; the following cycle changed=0 and out holds.
- Mismatch: strobe=1, addr=6, in=0xDEADBEEF -> out unchanged (0x12345678), changed=0. Then strobe=0, addr=5, in=0xFFFFFFFF -> no change.
- Back-to-back writes to addr 5: 0x1 then 0x2 -> out=0x1 then 0x2, changed high for two consecutive cycles. Repeat writing 0x2 -> changed pulses again.
- Width/INIT: WIDTH=16, INIT=0xABCD -> after reset out=0xABCD. Write 0xCAFE1234 -> out=0x1234.
- SETTING_REG_SHADOW_EN:
  - Write 0x55 -> out unchanged, changed=0. Assert commit -> out=0x55, changed=1.
  - Write 0x77 with commit in the same cycle -> out=0x77 next cycle.

Source files
------------

// File: rtl/settings_bus_pkg.sv
// Shared settings-bus widths, types and the address map used by
// blocks that host setting_register instances.
package settings_bus_pkg;

    localparam int unsigned SETTINGS_ADDR_WIDTH = 7;
    localparam int unsigned SETTINGS_DATA_WIDTH = 32;

    typedef logic [SETTINGS_ADDR_WIDTH-1:0] settings_addr_t;
    typedef logic [SETTINGS_DATA_WIDTH-1:0] settings_data_t;

    localparam settings_addr_t FREQADDR  = 7'd0;
    localparam settings_addr_t PHASEADDR = 7'd1;

endpackage

// File: rtl/settings_addr_match.sv
// Settings-bus write decode: strobe qualified by an exact address
// match; a low strobe masks any X on the address.
module settings_addr_match
    import settings_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SETTINGS_ADDR_WIDTH,
    parameter int unsigned MY_ADDR    = 0
) (
    input  logic                  strobe_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  match_o
);

    localparam logic [ADDR_WIDTH-1:0] MATCH = ADDR_WIDTH'(MY_ADDR);

    assign match_o = strobe_i & (addr_i == MATCH);

endmodule

// File: rtl/setting_register.sv
// One addressable setting on the settings bus with a write pulse.
// Define SETTING_REG_SHADOW_EN for a shadow copy applied on `commit`.
module setting_register
    import settings_bus_pkg::*;
#(
    parameter int unsigned     MY_ADDR    = 0,
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     ADDR_WIDTH = SETTINGS_ADDR_WIDTH,
    parameter logic [WIDTH-1:0] INIT      = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           strobe,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [SETTINGS_DATA_WIDTH-1:0] in,
`ifdef SETTING_REG_SHADOW_EN
    input  logic                           commit,
`endif
    output logic [WIDTH-1:0]               out,
    output logic                           changed
);

    if (WIDTH > SETTINGS_DATA_WIDTH || WIDTH < 1) begin : g_bad_width
        $error("setting_register: WIDTH must be 1..32");
    end
    if (MY_ADDR >= (1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("setting_register: MY_ADDR out of address range");
    end

    logic             we;
    logic [WIDTH-1:0] out_q, out_d;
    logic             changed_q, changed_d;

    settings_addr_match #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MY_ADDR   (MY_ADDR)
    ) u_match (
        .strobe_i(strobe),
        .addr_i  (addr),
        .match_o (we)
    );

`ifdef SETTING_REG_SHADOW_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;

    // Commit with a write in the same cycle passes the new data straight through
    always_comb begin
        shadow_d  = shadow_q;
        out_d     = out_q;
        changed_d = 1'b0;
        if (we) begin
            shadow_d = in[WIDTH-1:0];
        end
        if (commit) begin
            out_d     = we ? in[WIDTH-1:0] : shadow_q;
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_q <= INIT;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    always_comb begin
        out_d     = out_q;
        changed_d = 1'b0;
        if (we) begin
            out_d     = in[WIDTH-1:0];
            changed_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q     <= INIT;
            changed_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    assign out     = out_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_setting_register.sv
// Directed bench: a 32-bit instance and a 16-bit INIT=0xABCD instance
// sharing one bus, both at address 5.
module tb_setting_register;

    logic        clock;
    logic        reset;
    logic        strobe;
    logic [6:0]  addr;
    logic [31:0] in;
    logic [31:0] out;
    logic        changed;
    logic [15:0] out16;
    logic        changed16;
`ifdef SETTING_REG_SHADOW_EN
    logic        commit;
`endif

    int total = 0;
    int bad   = 0;

    setting_register #(
        .MY_ADDR(5), .WIDTH(32), .ADDR_WIDTH(7), .INIT(32'h0)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .strobe (strobe),
        .addr   (addr),
        .in     (in),
`ifdef SETTING_REG_SHADOW_EN
        .commit (commit),
`endif
        .out    (out),
        .changed(changed)
    );

    setting_register #(
        .MY_ADDR(5), .WIDTH(16), .ADDR_WIDTH(7), .INIT(16'hABCD)
    ) dut16 (
        .clock  (clock),
        .reset  (reset),
        .strobe (strobe),
        .addr   (addr),
        .in     (in),
`ifdef SETTING_REG_SHADOW_EN
        .commit (commit),
`endif
        .out    (out16),
        .changed(changed16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic [6:0] a,
                         input logic [31:0] d);
        strobe = s;
        addr   = a;
        in     = d;
    endtask

    initial begin
        reset  = 1'b0;
        drive(1'b0, 7'd0, 32'h0);
`ifdef SETTING_REG_SHADOW_EN
        commit = 1'b0;
`endif
        cycle();
        cycle();
        check("rst_out", out, 32'h0);
        check("rst_chg", {31'b0, changed}, 32'h0);
        check("rst_out16", {16'h0, out16}, 32'h0000ABCD);
        check("rst_chg16", {31'b0, changed16}, 32'h0);
        reset = 1'b1;

`ifdef SETTING_REG_SHADOW_EN
        drive(1'b1, 7'd5, 32'h55);
        cycle();
        check("sh_wr_out", out, 32'h0);
        check("sh_wr_chg", {31'b0, changed}, 32'h0);
        drive(1'b0, 7'd0, 32'h0);
        commit = 1'b1;
        cycle();
        check("sh_cm_out", out, 32'h55);
        check("sh_cm_chg", {31'b0, changed}, 32'h1);
        commit = 1'b0;
        cycle();
        check("sh_cm_end", {31'b0, changed}, 32'h0);
        drive(1'b1, 7'd5, 32'h77);
        commit = 1'b1;
        cycle();
        check("sh_wt_out", out, 32'h77);
        check("sh_wt_chg", {31'b0, changed}, 32'h1);
        drive(1'b0, 7'd0, 32'h0);
        cycle();
        check("sh_idle_cm", {31'b0, changed}, 32'h1);
        check("sh_idle_out", out, 32'h77);
        commit = 1'b0;
        cycle();
        check("sh_hold", out, 32'h77);
`else
        drive(1'b1, 7'd5, 32'h12345678);
        cycle();
        check("wr_out", out, 32'h12345678);
        check("wr_chg", {31'b0, changed}, 32'h1);
        check("wr_out16", {16'h0, out16}, 32'h00005678);
        drive(1'b0, 7'd0, 32'h0);
        cycle();
        check("wr_pulse_end", {31'b0, changed}, 32'h0);
        check("wr_hold", out, 32'h12345678);

        drive(1'b1, 7'd6, 32'hDEADBEEF);
        cycle();
        check("mis_out", out, 32'h12345678);
        check("mis_chg", {31'b0, changed}, 32'h0);
        drive(1'b0, 7'd5, 32'hFFFFFFFF);
        cycle();
        check("nostb_out", out, 32'h12345678);
        check("nostb_chg", {31'b0, changed}, 32'h0);
        drive(1'b1, 7'h45, 32'hAAAAAAAA);
        cycle();
        check("fulladdr_out", out, 32'h12345678);
        check("fulladdr_chg", {31'b0, changed}, 32'h0);
        strobe = 1'b0;
        addr   = 'x;
        in     = 'x;
        cycle();
        check("x_out", out, 32'h12345678);
        check("x_chg", {31'b0, changed}, 32'h0);

        drive(1'b1, 7'd5, 32'h1);
        cycle();
        check("b2b1_out", out, 32'h1);
        check("b2b1_chg", {31'b0, changed}, 32'h1);
        drive(1'b1, 7'd5, 32'h2);
        cycle();
        check("b2b2_out", out, 32'h2);
        check("b2b2_chg", {31'b0, changed}, 32'h1);
        cycle();
        check("same_out", out, 32'h2);
        check("same_chg", {31'b0, changed}, 32'h1);
        drive(1'b0, 7'd0, 32'h0);
        cycle();
        check("b2b_end", {31'b0, changed}, 32'h0);

        drive(1'b1, 7'd5, 32'hCAFE1234);
        cycle();
        check("trunc_out16", {16'h0, out16}, 32'h00001234);
        check("trunc_chg16", {31'b0, changed16}, 32'h1);

        #2;
        reset = 1'b0;
        #1;
        check("arst_out", out, 32'h0);
        check("arst_chg", {31'b0, changed}, 32'h0);
        check("arst_out16", {16'h0, out16}, 32'h0000ABCD);
        cycle();
        check("rst_wins", out, 32'h0);
        reset = 1'b1;
        drive(1'b1, 7'd5, 32'h99);
        cycle();
        check("first_wr", out, 32'h99);
        check("first_chg", {31'b0, changed}, 32'h1);
        drive(1'b0, 7'd0, 32'h0);
        cycle();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
